// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential RV32M multiply/divide unit
// Radix-2 shift-add multiply and restoring divide on magnitudes, one step per cycle, sign fixed up at the end.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

  localparam logic [5:0] LAST_STEP = 6'(XLEN - 1);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic                neg_q, neg_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          result_rd_q, result_rd_d;
  logic                busy_q, result_valid_q;

  logic                idle_or_done, accept;
  logic                sign_a, sign_b, div_zero, div_ovf;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next, div_next, mul_prod;
  logic [XLEN+1:0]     div_diff;
  logic [XLEN-1:0]     div_word, fix_res;

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign accept       = idle_or_done && start && !flush;
  assign stall        = accept || (state_q == ITER) || (state_q == FIX);

  // rs1 is signed for MUL/MULH/MULHSU/DIV/REM, rs2 only for MUL/MULH/DIV/REM
  assign sign_a   = (op != 3'd3) && (op != 3'd5) && (op != 3'd7) && operand_a[XLEN-1];
  assign sign_b   = ((op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6)) && operand_b[XLEN-1];
  assign mag_a    = sign_a ? -operand_a : operand_a;
  assign mag_b    = sign_b ? -operand_b : operand_b;
  assign div_zero = (operand_b == '0);
  assign div_ovf  = !op[0] && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);

  // Multiply: accumulate into the high half while the multiplier shifts out of the low half
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  // Divide: high half is the partial remainder, low half collects quotient bits
  assign div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};
  assign div_next = div_diff[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  assign mul_prod = neg_q ? -acc_q : acc_q;
  assign div_word = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign fix_res  = op_q[2] ? (neg_q ? -div_word : div_word)
                  : (op_q == 3'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    opnd_d      = opnd_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    result_d    = result_q;
    result_rd_d = result_rd_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            op_d  = op;
            rd_d  = rd_addr;
            cnt_d = '0;
            if (op[2] && div_zero) begin
              // Corner-case divides preload {remainder, quotient} and skip iteration
              acc_d   = {operand_a, {XLEN{1'b1}}};
              neg_d   = 1'b0;
              state_d = FIX;
            end else if (op[2] && div_ovf) begin
              acc_d   = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
              neg_d   = 1'b0;
              state_d = FIX;
            end else begin
              neg_d   = (op == 3'd6) ? sign_a : (sign_a ^ sign_b);
              opnd_d  = op[2] ? mag_b : mag_a;
              acc_d   = {{XLEN{1'b0}}, op[2] ? mag_a : mag_b};
              state_d = ITER;
            end
          end
        end
        ITER: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) state_d = FIX;
        end
        FIX: begin
          result_d    = fix_res;
          result_rd_d = rd_q;
          state_d     = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      op_q           <= '0;
      rd_q           <= '0;
      opnd_q         <= '0;
      neg_q          <= 1'b0;
      cnt_q          <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_rd_q    <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      rd_q           <= rd_d;
      opnd_q         <= opnd_d;
      neg_q          <= neg_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_rd_q    <= result_rd_d;
      busy_q         <= (state_d == ITER) || (state_d == FIX);
      result_valid_q <= (state_d == DONE);
    end
  end

  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign result_rd    = result_rd_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq
// Expected results are queued at issue and matched when result_valid pulses.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [4:0]  rd_addr = '0;
  logic        flush = 1'b0;
  logic        stall, busy, result_valid;
  logic [31:0] result;
  logic [4:0]  result_rd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t vecs [0:12] = '{
    '{3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB},
    '{3'd1, 32'h80000000,  32'h80000000, 32'h40000000},
    '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF},
    '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE},
    '{3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD},
    '{3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF},
    '{3'd5, 32'd100,       32'd7,        32'd14},
    '{3'd7, 32'd100,       32'd7,        32'd2},
    '{3'd5, 32'h1234,      32'd0,        32'hFFFFFFFF},
    '{3'd6, 32'h1234,      32'd0,        32'h1234},
    '{3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000},
    '{3'd6, 32'h80000000,  32'hFFFFFFFF, 32'd0},
    '{3'd4, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFFF}
  };

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .rd_addr(rd_addr),
    .flush(flush), .stall(stall), .busy(busy), .result_valid(result_valid),
    .result(result), .result_rd(result_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb2, ub_s;
    logic [63:0] ua, ub, p;
    logic ovf;
    sa   = {{32{a[31]}}, a};
    sb2  = {{32{b[31]}}, b};
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    ub_s = ub;
    ovf  = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (f)
      3'd0: begin p = ua * ub;     return p[31:0];  end
      3'd1: begin p = sa * sb2;    return p[63:32]; end
      3'd2: begin p = sa * ub_s;   return p[63:32]; end
      3'd3: begin p = ua * ub;     return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && ((b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 2;
    return 34;
  endfunction

  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("result_rd", result_rd, e.rd);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic set_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    op = f; operand_a = a; operand_b = b; rd_addr = rd; start = 1'b1;
    sb.push_back('{exp, rd, cyc + lat_of(f, a, b)});
    #1 chk("stall_accept", stall, 1);
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp);
    @(negedge clk);
    set_op(f, a, b, rd, exp);
  endtask

  task automatic wait_done(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (busy) nbusy++;
      if (sb.size() == 0) return;
    end
    chk("timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp);
    int nb;
    drive(f, a, b, rd, exp);
    wait_done(nb);
    chk("busy_cycles", nb, lat_of(f, a, b) - 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int n0, nb;

    idle_cycles(3);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_rd", result_rd, 0);
    chk("rst_stall", stall, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) run(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].e);

    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i[1:0] == 2'd3) b = {28'b0, 4'($urandom)};
      run(f, a, b, 5'($urandom), ref_res(f, a, b));
    end

    // Flush at ITER step 10: no result, then a clean operation
    drive(3'd5, 32'd1000, 32'd3, 5'd9, 32'd0);
    void'(sb.pop_back());
    idle_cycles(1);
    start = 1'b0;
    idle_cycles(10);
    chk("flush_stall_iter", stall, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_valid", result_valid, 0);
    chk("flush_stall", stall, 0);
    idle_cycles(40);
    run(3'd0, 32'd12345, 32'd678, 5'd5, ref_res(3'd0, 32'd12345, 32'd678));

    // Back-to-back start held in DONE
    drive(3'd1, 32'hDEADBEEF, 32'h12345678, 5'd11, ref_res(3'd1, 32'hDEADBEEF, 32'h12345678));
    n0 = cyc;
    for (int i = 0; i < 40 && cyc != n0 + 34; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("b2b_valid", result_valid, 1);
    set_op(3'd7, 32'hCAFEF00D, 32'd1234, 5'd12, ref_res(3'd7, 32'hCAFEF00D, 32'd1234));
    wait_done(nb);
    chk("b2b_busy", nb, 33);

    // Reset in the middle of ITER
    drive(3'd3, 32'hFFFF0000, 32'h0000FFFF, 5'd20, 32'd0);
    sb.delete();
    idle_cycles(1);
    start = 1'b0;
    idle_cycles(5);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_rd", result_rd, 0);
    chk("midrst_stall", stall, 0);
    idle_cycles(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE or DONE.
REQ-005 SHALL have port op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have port operand_a  input  32  rs1 value (multiplicand or dividend).
REQ-007 SHALL have port operand_b  input  32  rs2 value (multiplier or divisor).
REQ-008 SHALL have port rd_addr  input  5  destination register tag.
REQ-009 SHALL have port flush  input  1  abort the in-flight operation.
REQ-010 SHALL have port stall  output  1  combinational pipeline hold request.
REQ-011 SHALL have port busy  output  1  registered; high in ITER or FIX.
REQ-012 SHALL have port result_valid  output  1  registered single-cycle pulse.
REQ-013 SHALL have port result  output  32  final value; meaningful only while result_valid is high.
REQ-014 SHALL have port result_rd  output  5  rd_addr captured at start; meaningful only while result_valid is high.

Function
REQ-015 SHALL implement FSM with states IDLE, ITER, FIX, DONE.
REQ-016 SHALL accept start when state is IDLE or DONE and flush is low: capture op, rd_addr, operand magnitudes and result sign, set iteration count to 0.
REQ-017 SHALL, on an accepted start, move to ITER, except for the special divides in REQ-022/REQ-023, which move directly to FIX.
REQ-018 SHALL perform in ITER exactly one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide) on 32-bit unsigned magnitudes with a 64-bit accumulator, then move to FIX after 32 steps.
REQ-019 SHALL apply sign correction in FIX (two's-complement negate where required), select the result (low word for MUL, high word for MULH*, quotient for DIV*, remainder for REM*), and move to DONE.
REQ-020 SHALL assert result_valid for exactly the one cycle spent in DONE; a normal operation thus shows result_valid 34 cycles after the start edge (1 accept + 32 ITER + 1 FIX), and a special-case divide shows it 2 cycles after.
REQ-021 SHALL apply signedness rules: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned; remainder takes the dividend's sign; quotient sign = sign(a) XOR sign(b).
REQ-022 SHALL handle divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = operand_a.
REQ-023 SHALL handle signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
REQ-024 SHALL drive stall = (start AND state in {IDLE, DONE} AND NOT flush) OR state in {ITER, FIX}.
REQ-025 SHALL ignore start in ITER and FIX without disturbing the operation.
REQ-026 SHALL treat start in DONE as back-to-back: result_valid for the old operation still pulses that cycle, and the new operation is captured at the same edge.
REQ-027 SHALL, when flush is high, move to IDLE at the next edge from any state, emit no result_valid for the aborted operation, and accept no start that cycle; flush in DONE does not suppress the current-cycle pulse.
REQ-028 SHALL hold result and result_rd stable from DONE until the next DONE.

Reset
REQ-029 SHALL, while reset_n is low at a rising edge, set state to IDLE and clear busy, result_valid, result, result_rd, the iteration count and the accumulator to 0; reset overrides flush and start.
REQ-030 SHALL, on reset mid-operation, discard the operation, leave no pending result, and drop stall low in the cycle after the reset edge if start is low.

Verification
REQ-031 SHALL pass: MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, result_valid 34 cycles after start, busy high for 33 cycles.
REQ-032 SHALL pass: MULH a=b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 SHALL pass: DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-034 SHALL pass: DIVU a=0x1234, b=0 -> 0xFFFFFFFF; REM a=0x1234, b=0 -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; each with result_valid 2 cycles after start.
REQ-035 SHALL pass: flush asserted at ITER step 10 -> IDLE next cycle, no result_valid; a subsequent start with rd_addr=5 completes normally with result_rd=5.
REQ-036 SHALL pass: start held high in DONE with new operands -> old result pulses, new result follows 34 cycles later; reset_n low during ITER -> all outputs 0 next cycle.
